// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised interrupt controller.
// Latches interrupt pulses into a pending register and masks them with
// per-source enables. The lowest-numbered enabled pending source is offered
// to the core through a registered request / ack / end-of-interrupt handshake.
module irq_ctrl #(
   parameter int NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [7:0]         enable_in,
   input  logic               enable_write,
   input  logic [7:0]         pending_clear_in,
   input  logic               pending_clear_write,
   input  logic [7:0]         ctrl_in,
   input  logic               ctrl_write,
   output logic [7:0]         enable_out,
   output logic [7:0]         pending_out,
   output logic [7:0]         ctrl_out,
   output logic               int_req,
   output logic [2:0]         int_vector,
   input  logic               int_ack,
   input  logic               int_eoi,
   output logic               in_service
);

   // Register bits above NUM_IRQ-1 are never stored, so they read back 0.
   localparam logic [7:0] VALID_MASK = 8'((9'd1 << NUM_IRQ) - 9'd1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [7:0]  enable_reg;
   logic [7:0]  pending_reg, pending_next;
   logic        gie_reg;
   logic [2:0]  vector_reg, vector_next;
   logic [7:0]  irq_ext;
   logic [7:0]  clr;
   logic [7:0]  ack_clr;
   logic [7:0]  candidate;
   logic [2:0]  cand_idx;
   logic        cand_valid;
   logic [6:0]  unused_ctrl_bits;

   assign unused_ctrl_bits = ctrl_in[7:1];

   // Widen the source pulses to the 8-bit register layout.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_irq_ext
         if (gi < NUM_IRQ) begin : g_used
            assign irq_ext[gi] = irq_in[gi];
         end else begin : g_unused
            assign irq_ext[gi] = 1'b0;
         end
      end
   endgenerate

   assign candidate  = pending_reg & enable_reg;
   assign cand_valid = gie_reg && (candidate != 8'd0);

   // Priority encoder: scan high to low so the lowest set index wins.
   always_comb begin
      cand_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (candidate[i]) cand_idx = 3'(i);
      end
   end

   // Handshake FSM next-state logic; ack also clears the serviced pending bit.
   always_comb begin
      state_next  = state_reg;
      vector_next = vector_reg;
      ack_clr     = 8'd0;
      case (state_reg)
         IDLE: begin
            if (cand_valid) begin
               vector_next = cand_idx;
               state_next  = REQ;
            end
         end
         REQ: begin
            if (int_ack) begin
               ack_clr    = 8'd1 << vector_reg;
               state_next = SERVICE;
            end
         end
         SERVICE: begin
            if (int_eoi) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Pending update: clears first, then new pulses, so a set always wins.
   always_comb begin
      clr          = (pending_clear_write ? pending_clear_in : 8'd0) | ack_clr;
      pending_next = ((pending_reg & ~clr) | irq_ext) & VALID_MASK;
   end

   // Software-visible enable and control registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable_reg <= 8'd0;
         gie_reg    <= 1'b0;
      end else begin
         if (enable_write) enable_reg <= enable_in & VALID_MASK;
         if (ctrl_write)   gie_reg    <= ctrl_in[0];
      end
   end

   // Pending register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pending_reg <= 8'd0;
      else       pending_reg <= pending_next;
   end

   // Handshake state and latched vector.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         vector_reg <= 3'd0;
      end else begin
         state_reg  <= state_next;
         vector_reg <= vector_next;
      end
   end

   assign enable_out  = enable_reg;
   assign pending_out = pending_reg;
   assign ctrl_out    = {7'd0, gie_reg};
   assign int_req     = (state_reg == REQ);
   assign in_service  = (state_reg == SERVICE);
   assign int_vector  = vector_reg;

endmodule
